// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM test path: LFSR8 constants and the
// checker state encoding.
package sdram_test_pkg;

  localparam logic [7:0] LFSR8_SEED_DEFAULT = 8'h20;
  // x^8 + x^4 + x^3 + x^2 + 1, with the x^8 term implied by the shift-out bit
  localparam logic [7:0] LFSR8_TAPS         = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } chk_state_t;

endpackage

// File: rtl/sdram_lfsr8_step.sv
// One Galois step of the 8-bit pattern LFSR. This is the single place the
// polynomial is defined, so the generator and the checker share it.
module sdram_lfsr8_step
  import sdram_test_pkg::*;
(
  input  logic [7:0] cur_i,
  output logic [7:0] nxt_o
);

  assign nxt_o = {cur_i[6:0], 1'b0} ^ (cur_i[7] ? LFSR8_TAPS : 8'h00);

endmodule

// File: rtl/sdram_lfsr8_checker.sv
// Read-side checker: regenerates the LFSR byte stream, compares each read
// beat, counts mismatches, and reports pass/fail at the end of each burst.
module sdram_lfsr8_checker
  import sdram_test_pkg::*;
#(
  parameter int unsigned SEED      = LFSR8_SEED_DEFAULT,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load,
  input  logic [7:0]       ldata,
  input  logic             rd_valid,
  input  logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_err_idx,
  output logic [7:0]       first_err_exp,
  output logic [7:0]       first_err_got,
  output logic [7:0]       expected
);

  localparam logic [7:0]  SEED_B   = 8'(SEED);
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  chk_state_t       state_q;
  logic [7:0]       exp_q;
  logic [7:0]       exp_step;
  logic [15:0]      cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             busy_q, done_q, pass_q, fail_q;
  logic [15:0]      fe_idx_q;
  logic [7:0]       fe_exp_q, fe_got_q;
  logic             mism;
  logic             last_beat;

  sdram_lfsr8_step u_step (
    .cur_i (exp_q),
    .nxt_o (exp_step)
  );

  assign mism      = (rd_data != exp_q);
  assign last_beat = (cnt_q == LAST_IDX);
  assign err_d     = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      exp_q    <= SEED_B;
      cnt_q    <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      fe_idx_q <= '0;
      fe_exp_q <= '0;
      fe_got_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_CHECK;
            exp_q    <= SEED_B;
            cnt_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_got_q <= '0;
          end else if (load) begin
            exp_q <= ldata;
          end
        end
        ST_CHECK: begin
          if (rd_valid) begin
            cnt_q <= cnt_q + 16'd1;
            // A coincident load replaces the stepped value; the beat itself
            // was already compared against the pre-load expected byte.
            exp_q <= load ? ldata : exp_step;
            if (mism) begin
              err_q <= err_d;
              if (err_q == '0) begin
                fe_idx_q <= cnt_q;
                fe_exp_q <= exp_q;
                fe_got_q <= rd_data;
              end
            end
            if (last_beat) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= !mism && (err_q == '0);
              fail_q  <= mism || (err_q != '0);
            end
          end else if (load) begin
            exp_q <= ldata;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (load) begin
            exp_q <= ldata;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign err_count     = err_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_got = fe_got_q;
  assign expected      = exp_q;

endmodule

// File: tb/tb_sdram_lfsr8_checker.sv
// Scoreboard bench: two checker instances (BURST_LEN=4 and a 2-bit error
// counter with BURST_LEN=8) driven with directed read-back streams.
module tb_sdram_lfsr8_checker;

  typedef struct {
    logic        p;
    logic [15:0] errc;
    logic [15:0] idx;
    logic [7:0]  fe;
    logic [7:0]  fg;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [7:0] ldata = 8'h00;

  logic start_a = 1'b0, rv_a = 1'b0;
  logic [7:0] rd_a = 8'h00;
  logic busy_a, done_a, pass_a, fail_a;
  logic [15:0] err_a, fidx_a;
  logic [7:0] fexp_a, fgot_a, expd_a;

  logic start_b = 1'b0, rv_b = 1'b0;
  logic [7:0] rd_b = 8'h00;
  logic busy_b, done_b, pass_b, fail_b;
  logic [1:0] err_b;
  logic [15:0] fidx_b;
  logic [7:0] fexp_b, fgot_b, expd_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int failures = 0;
  int ndone_a = 0;
  int ndone_b = 0;
  int nd0;

  always #5 clk = ~clk;

  sdram_lfsr8_checker #(.SEED(32), .BURST_LEN(4), .ERR_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .load(load), .ldata(ldata),
    .rd_valid(rv_a), .rd_data(rd_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .err_count(err_a), .first_err_idx(fidx_a),
    .first_err_exp(fexp_a), .first_err_got(fgot_a), .expected(expd_a)
  );

  sdram_lfsr8_checker #(.SEED(32), .BURST_LEN(8), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .load(1'b0), .ldata(8'h00),
    .rd_valid(rv_b), .rd_data(rd_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail(fail_b), .err_count(err_b), .first_err_idx(fidx_b),
    .first_err_exp(fexp_b), .first_err_got(fgot_b), .expected(expd_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [15:0] ec, input logic [15:0] idx,
                              input logic [7:0] fe, input logic [7:0] fg);
    exp_t e;
    e.p = p; e.errc = ec; e.idx = idx; e.fe = fe; e.fg = fg;
    return e;
  endfunction

  // Monitors: pop one expected result per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_a) begin
      ndone_a++;
      if (q_a.size() == 0) chk("A unexpected done", q_a.size(), 1);
      else begin
        e = q_a.pop_front();
        chk("A pass", pass_a, e.p);
        chk("A fail", fail_a, !e.p);
        chk("A err_count", err_a, e.errc);
        chk("A first_err_idx", fidx_a, e.idx);
        chk("A first_err_exp", fexp_a, e.fe);
        chk("A first_err_got", fgot_a, e.fg);
        chk("A busy at done", busy_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_b) begin
      ndone_b++;
      if (q_b.size() == 0) chk("B unexpected done", q_b.size(), 1);
      else begin
        e = q_b.pop_front();
        chk("B pass", pass_b, e.p);
        chk("B fail", fail_b, !e.p);
        chk("B err_count", err_b, e.errc);
        chk("B first_err_idx", fidx_b, e.idx);
        chk("B first_err_exp", fexp_b, e.fe);
        chk("B first_err_got", fgot_b, e.fg);
      end
    end
  end

  task automatic drive_a(input logic v, input logic [7:0] d, input logic ld, input logic [7:0] lv);
    rv_a = v; rd_a = d; load = ld; ldata = lv;
    @(posedge clk); #1;
    rv_a = 1'b0; load = 1'b0;
  endtask

  task automatic beat_a(input logic [7:0] d);
    drive_a(1'b1, d, 1'b0, 8'h00);
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic start_burst_a(input exp_t e);
    q_a.push_back(e);
    nd0 = ndone_a;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic finish_a(input string nm);
    for (int i = 0; i < 8 && ndone_a == nd0; i++) idle_a(1);
    chk(nm, ndone_a - nd0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset pass", pass_a, 0);
    chk("reset fail", fail_a, 0);
    chk("reset err_count", err_a, 0);
    chk("reset first_err_idx", fidx_a, 0);
    chk("reset expected", expd_a, 8'h20);
    reset = 1'b0;
    idle_a(1);

    // Beat while idle must be ignored
    beat_a(8'hFF);
    chk("idle beat err_count", err_a, 0);
    chk("idle beat expected", expd_a, 8'h20);

    // Clean burst
    start_burst_a(mk(1'b1, 16'd0, 16'd0, 8'h00, 8'h00));
    chk("busy in check", busy_a, 1);
    beat_a(8'h20); beat_a(8'h40); beat_a(8'h80); beat_a(8'h1D);
    chk("done right after last beat", done_a, 1);
    finish_a("clean done");

    // Single error at beat 2
    start_burst_a(mk(1'b0, 16'd1, 16'd2, 8'h80, 8'h81));
    beat_a(8'h20); beat_a(8'h40); beat_a(8'h81);
    chk("err visible next cycle", err_a, 1);
    beat_a(8'h1D);
    finish_a("single err done");

    // Gapped valid, with an ignored start in the gap
    start_burst_a(mk(1'b1, 16'd0, 16'd0, 8'h00, 8'h00));
    beat_a(8'h20);
    idle_a(1);
    start_a = 1'b1; idle_a(1); start_a = 1'b0;
    idle_a(1);
    chk("gap holds expected", expd_a, 8'h40);
    beat_a(8'h40); idle_a(1); beat_a(8'h80); beat_a(8'h1D);
    finish_a("gapped done");

    // Resync by standalone load
    start_burst_a(mk(1'b1, 16'd0, 16'd0, 8'h00, 8'h00));
    beat_a(8'h20);
    drive_a(1'b0, 8'h00, 1'b1, 8'h1D);
    chk("load sets expected", expd_a, 8'h1D);
    beat_a(8'h1D); beat_a(8'h3A); beat_a(8'h74);
    finish_a("resync done");

    // Load coinciding with a beat
    start_burst_a(mk(1'b1, 16'd0, 16'd0, 8'h00, 8'h00));
    beat_a(8'h20);
    drive_a(1'b1, 8'h40, 1'b1, 8'h1D);
    chk("load+beat expected", expd_a, 8'h1D);
    chk("load+beat err_count", err_a, 0);
    beat_a(8'h1D); beat_a(8'h3A);
    finish_a("load+beat done");

    // Reset mid-burst
    nd0 = ndone_a;
    start_a = 1'b1; idle_a(1); start_a = 1'b0;
    beat_a(8'h20); beat_a(8'h99);
    reset = 1'b1;
    #2;
    chk("midreset busy", busy_a, 0);
    chk("midreset done", done_a, 0);
    chk("midreset pass", pass_a, 0);
    chk("midreset fail", fail_a, 0);
    chk("midreset err_count", err_a, 0);
    chk("midreset first_err_idx", fidx_a, 0);
    chk("midreset first_err_got", fgot_a, 0);
    chk("midreset expected", expd_a, 8'h20);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_a(4);
    chk("no done after reset", ndone_a - nd0, 0);
    start_burst_a(mk(1'b1, 16'd0, 16'd0, 8'h00, 8'h00));
    beat_a(8'h20); beat_a(8'h40); beat_a(8'h80); beat_a(8'h1D);
    finish_a("post-reset done");

    // Saturation on the 2-bit error counter instance
    q_b.push_back(mk(1'b0, 16'd3, 16'd0, 8'h20, 8'h00));
    nd0 = ndone_b;
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rv_b = 1'b1; rd_b = 8'h00;
      @(posedge clk); #1;
    end
    rv_b = 1'b0;
    chk("B saturated err_count", err_b, 3);
    for (int i = 0; i < 8 && ndone_b == nd0; i++) begin
      @(posedge clk); #1;
    end
    chk("B done", ndone_b - nd0, 1);

    idle_a(3);
    chk("A queue drained", q_a.size(), 0);
    chk("B queue drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
